neuron_index_sequencer: RTL and testbench

NEURON_INDEX_SEQUENCER -- requirements
Module: neuron_index_sequencer

---
 rtl/neuron_index_sequencer.sv | 128 ++++++++++++
 tb/tb_neuron_index_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_index_sequencer.sv
// Neuron index sequencer: walks (index, layer) over a programmed grid,
// advancing one index every PRESCALE clocks, with stall, clear and done pulse.
module neuron_index_sequencer #(
  parameter int unsigned IDX_W    = 32,
  parameter int unsigned LAYER_W  = 8,
  parameter int unsigned PRESCALE = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               clear,
  input  logic               stall,
  input  logic [IDX_W-1:0]   num_idx,
  input  logic [LAYER_W-1:0] num_layers,
  output logic [IDX_W-1:0]   index,
  output logic [LAYER_W-1:0] layer,
  output logic               step,
  output logic               busy,
  output logic               done
);

  localparam int unsigned     SUB_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [SUB_W-1:0]   sub;
  logic [SUB_W-1:0]   sub_d;
  logic [IDX_W-1:0]   index_d;
  logic [LAYER_W-1:0] layer_d;
  logic [IDX_W-1:0]   num_idx_q;
  logic [IDX_W-1:0]   num_idx_d;
  logic [LAYER_W-1:0] num_layers_q;
  logic [LAYER_W-1:0] num_layers_d;
  logic               busy_d;
  logic               done_d;
  logic               idx_last;
  logic               lay_last;

  // Step strobe decoded from registered state; stall suppresses it.
  assign step     = (state == RUN) && (sub == SUB_LAST) && !stall;
  assign idx_last = (index == num_idx_q - IDX_W'(1));
  assign lay_last = (layer == num_layers_q - LAYER_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      sub          <= '0;
      index        <= '0;
      layer        <= '0;
      num_idx_q    <= IDX_W'(1);
      num_layers_q <= LAYER_W'(1);
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      sub          <= sub_d;
      index        <= index_d;
      layer        <= layer_d;
      num_idx_q    <= num_idx_d;
      num_layers_q <= num_layers_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  always_comb begin
    state_d      = state;
    sub_d        = sub;
    index_d      = index;
    layer_d      = layer;
    num_idx_d    = num_idx_q;
    num_layers_d = num_layers_q;

    case (state)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          sub_d        = '0;
          index_d      = '0;
          layer_d      = '0;
          // Zero counts are promoted to one so every run has at least one step.
          num_idx_d    = (num_idx == '0) ? IDX_W'(1) : num_idx;
          num_layers_d = (num_layers == '0) ? LAYER_W'(1) : num_layers;
        end
      end
      RUN: begin
        if (!stall) begin
          sub_d = (sub == SUB_LAST) ? '0 : sub + SUB_W'(1);
          if (sub == SUB_LAST) begin
            if (!idx_last) begin
              index_d = index + IDX_W'(1);
            end else if (!lay_last) begin
              index_d = '0;
              layer_d = layer + LAYER_W'(1);
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear overrides everything, including the final step.
    if (clear) begin
      state_d = IDLE;
      sub_d   = '0;
      index_d = '0;
      layer_d = '0;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_neuron_index_sequencer.sv
// Self-checking bench: two sequencers (PRESCALE 10 and 1) driven in parallel
// and compared every cycle against an arithmetic model of elapsed run time.
module tb_neuron_index_sequencer;

  localparam int unsigned IW = 32;
  localparam int unsigned LW = 8;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          clear;
  logic          stall;
  logic [IW-1:0] num_idx;
  logic [LW-1:0] num_layers;
  logic [IW-1:0] index_o [2];
  logic [LW-1:0] layer_o [2];
  logic          step_o  [2];
  logic          busy_o  [2];
  logic          done_o  [2];

  int checks;
  int errors;
  int cyc;

  // Model: mode 0 idle, 1 run, 2 done; m_t counts non-stalled run cycles.
  int     m_mode [2];
  longint m_t    [2];
  longint m_n    [2];
  longint m_l    [2];
  longint m_idx  [2];
  longint m_lay  [2];
  int     steps    [2];
  int     busy_cnt [2];
  int     done_at  [2];

  neuron_index_sequencer #(.IDX_W(IW), .LAYER_W(LW), .PRESCALE(10)) dut10 (
    .clk(clk), .rstn(rstn), .start(start), .clear(clear), .stall(stall),
    .num_idx(num_idx), .num_layers(num_layers),
    .index(index_o[0]), .layer(layer_o[0]), .step(step_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  neuron_index_sequencer #(.IDX_W(IW), .LAYER_W(LW), .PRESCALE(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .clear(clear), .stall(stall),
    .num_idx(num_idx), .num_layers(num_layers),
    .index(index_o[1]), .layer(layer_o[1]), .step(step_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint pval(int k);
    return (k == 0) ? 64'd10 : 64'd1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0;
      m_t[k]    = 0;
      m_n[k]    = 1;
      m_l[k]    = 1;
      m_idx[k]  = 0;
      m_lay[k]  = 0;
    end
  endfunction

  function automatic void clear_stats();
    for (int k = 0; k < 2; k++) begin
      steps[k]    = 0;
      busy_cnt[k] = 0;
      done_at[k]  = -1;
    end
  endfunction

  // One clock: compare outputs against the model, then advance the model at the edge.
  task automatic tick();
    longint p;
    longint blk;
    longint e_idx;
    longint e_lay;
    bit     e_step;
    bit     e_busy;
    bit     e_done;
    #1;
    for (int k = 0; k < 2; k++) begin
      p      = pval(k);
      e_step = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_idx  = m_idx[k];
      e_lay  = m_lay[k];
      if (m_mode[k] == 1) begin
        blk    = m_t[k] / p;
        e_idx  = blk % m_n[k];
        e_lay  = blk / m_n[k];
        e_busy = 1'b1;
        e_step = ((m_t[k] % p) == p - 1) && !stall;
      end else if (m_mode[k] == 2) begin
        e_idx  = m_n[k] - 1;
        e_lay  = m_l[k] - 1;
        e_done = 1'b1;
      end
      checks++;
      if (index_o[k] !== IW'(e_idx))
        $display("FAIL index dut%0d cyc %0d got %0d exp %0d", k, cyc, index_o[k], e_idx);
      if (index_o[k] !== IW'(e_idx)) errors++;
      checks++;
      if (layer_o[k] !== LW'(e_lay)) begin
        errors++;
        $display("FAIL layer dut%0d cyc %0d got %0d exp %0d", k, cyc, layer_o[k], e_lay);
      end
      checks++;
      if (step_o[k] !== e_step) begin
        errors++;
        $display("FAIL step dut%0d cyc %0d got %b exp %b", k, cyc, step_o[k], e_step);
      end
      checks++;
      if (busy_o[k] !== e_busy) begin
        errors++;
        $display("FAIL busy dut%0d cyc %0d got %b exp %b", k, cyc, busy_o[k], e_busy);
      end
      checks++;
      if (done_o[k] !== e_done) begin
        errors++;
        $display("FAIL done dut%0d cyc %0d got %b exp %b", k, cyc, done_o[k], e_done);
      end
      if (step_o[k] === 1'b1) steps[k]++;
      if (busy_o[k] === 1'b1) busy_cnt[k]++;
      if (done_o[k] === 1'b1) done_at[k] = cyc;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        m_mode[k] = 0;
        m_idx[k]  = 0;
        m_lay[k]  = 0;
      end else if (m_mode[k] == 0) begin
        if (start) begin
          m_mode[k] = 1;
          m_t[k]    = 0;
          m_n[k]    = (num_idx == 0) ? 1 : longint'(num_idx);
          m_l[k]    = (num_layers == 0) ? 1 : longint'(num_layers);
        end
      end else if (m_mode[k] == 1) begin
        if (!stall) begin
          if (m_t[k] == pval(k) * m_n[k] * m_l[k] - 1) m_mode[k] = 2;
          else m_t[k]++;
        end
      end else begin
        m_mode[k] = 0;
        m_idx[k]  = m_n[k] - 1;
        m_lay[k]  = m_l[k] - 1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic launch(input logic [IW-1:0] n, input logic [LW-1:0] l);
    clear_stats();
    num_idx    = n;
    num_layers = l;
    start      = 1'b1;
    cyc        = 0;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; clear = 1'b0; stall = 1'b0;
    num_idx = '0; num_layers = '0;
    model_reset();
    clear_stats();
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({index_o[k], layer_o[k], step_o[k], busy_o[k], done_o[k]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got idx %0d lay %0d s%b b%b d%b exp all 0",
                 k, index_o[k], layer_o[k], step_o[k], busy_o[k], done_o[k]);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    cyc  = 0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_basic_sequence();
    launch(3, 2);
    for (int i = 0; i < 70; i++) tick();
    checks++;
    if (done_at[0] != 61) begin errors++; $display("FAIL basic_done_cycle got %0d exp 61", done_at[0]); end
    checks++;
    if (steps[0] != 6) begin errors++; $display("FAIL basic_steps got %0d exp 6", steps[0]); end
    checks++;
    if (busy_cnt[0] != 60) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 60", busy_cnt[0]); end
    checks++;
    if (done_at[1] != 7 || steps[1] != 6) begin
      errors++;
      $display("FAIL basic_p1 got done %0d steps %0d exp done 7 steps 6", done_at[1], steps[1]);
    end
  endtask

  task automatic test_stall();
    launch(3, 2);
    for (int i = 0; i < 75; i++) begin
      stall = (cyc >= 13 && cyc <= 17);
      tick();
    end
    stall = 1'b0;
    checks++;
    if (done_at[0] != 66) begin errors++; $display("FAIL stall_done_cycle got %0d exp 66", done_at[0]); end
    checks++;
    if (steps[0] != 6) begin errors++; $display("FAIL stall_steps got %0d exp 6", steps[0]); end
    checks++;
    if (busy_cnt[0] != 65) begin errors++; $display("FAIL stall_busy_cycles got %0d exp 65", busy_cnt[0]); end
  endtask

  task automatic test_zero_counts();
    launch(0, 0);
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (done_at[1] != 2 || steps[1] != 1) begin
      errors++;
      $display("FAIL zero_counts_p1 got done %0d steps %0d exp done 2 steps 1", done_at[1], steps[1]);
    end
    checks++;
    if (done_at[0] != 11 || steps[0] != 1) begin
      errors++;
      $display("FAIL zero_counts_p10 got done %0d steps %0d exp done 11 steps 1", done_at[0], steps[0]);
    end
  endtask

  task automatic test_async_reset();
    launch(3, 2);
    for (int i = 0; i < 54; i++) tick();
    checks++;
    if (index_o[0] !== IW'(2) || layer_o[0] !== LW'(1)) begin
      errors++;
      $display("FAIL areset_position got idx %0d lay %0d exp idx 2 lay 1", index_o[0], layer_o[0]);
    end
    #2 rstn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({index_o[k], layer_o[k], step_o[k], busy_o[k], done_o[k]} !== '0) begin
        errors++;
        $display("FAIL areset_outputs dut%0d got idx %0d lay %0d s%b b%b d%b exp all 0",
                 k, index_o[k], layer_o[k], step_o[k], busy_o[k], done_o[k]);
      end
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (done_at[0] != -1) begin errors++; $display("FAIL areset_no_done got %0d exp -1", done_at[0]); end
    launch(3, 2);
    for (int i = 0; i < 70; i++) tick();
    checks++;
    if (done_at[0] != 61 || steps[0] != 6) begin
      errors++;
      $display("FAIL areset_rerun got done %0d steps %0d exp done 61 steps 6", done_at[0], steps[0]);
    end
  endtask

  task automatic test_clear_and_start_ignore();
    launch(3, 2);
    for (int i = 0; i < 12; i++) tick();
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (index_o[0] !== '0 || layer_o[0] !== '0 || busy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle got idx %0d lay %0d busy %b exp 0 0 0", index_o[0], layer_o[0], busy_o[0]);
    end
    for (int i = 0; i < 70; i++) tick();
    checks++;
    if (done_at[0] != -1) begin errors++; $display("FAIL clear_no_done got %0d exp -1", done_at[0]); end
    launch(3, 2);
    for (int i = 0; i < 70; i++) begin
      start      = (cyc <= 40);
      num_idx    = 7;
      num_layers = 5;
      tick();
    end
    start = 1'b0;
    checks++;
    if (done_at[0] != 61 || steps[0] != 6) begin
      errors++;
      $display("FAIL start_ignored got done %0d steps %0d exp done 61 steps 6", done_at[0], steps[0]);
    end
    for (int i = 0; i < 40; i++) tick();
  endtask

  task automatic test_random();
    clear_stats();
    for (int i = 0; i < 2500; i++) begin
      start      = ($urandom_range(0, 99) < 30);
      clear      = ($urandom_range(0, 199) == 0);
      stall      = ($urandom_range(0, 99) < 25);
      num_idx    = IW'($urandom_range(0, 4));
      num_layers = LW'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0; clear = 1'b0; stall = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_basic_sequence();
    test_stall();
    test_zero_counts();
    test_async_reset();
    test_clear_and_start_ignore();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
